// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU operation codes,
// opcode/funct constants, ALU control classes and the FSM state encoding.
package mips_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_NOR = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'd0,
        ALUOP_SUB    = 2'd1,
        ALUOP_FUNCT  = 2'd2,
        ALUOP_OPCODE = 2'd3
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    // Shifts take their operand from rt, so ALUSrcA must select reg B.
    function automatic logic is_shift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: maps the FSM's ALU class plus opcode/funct onto
// the 4-bit ALU operation code and flags unsupported R-type functs.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  aluop_t     alu_op_i,
    output logic [3:0] alu_operation_o,
    output logic       funct_valid_o
);

    logic [3:0] funct_op;
    logic [3:0] opcode_op;

    always_comb begin
        funct_op      = ALU_AND;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  funct_op = ALU_ADD;
            FN_SUB:  funct_op = ALU_SUB;
            FN_AND:  funct_op = ALU_AND;
            FN_OR:   funct_op = ALU_OR;
            FN_NOR:  funct_op = ALU_NOR;
            FN_SLL:  funct_op = ALU_SLL;
            FN_SRL:  funct_op = ALU_SRL;
            default: funct_valid_o = 1'b0;
        endcase
    end

    always_comb begin
        opcode_op = ALU_ADD;
        case (opcode_i)
            OP_ANDI: opcode_op = ALU_AND;
            OP_ORI:  opcode_op = ALU_OR;
            OP_LUI:  opcode_op = ALU_LUI;
            default: opcode_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_operation_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD:    alu_operation_o = ALU_ADD;
            ALUOP_SUB:    alu_operation_o = ALU_SUB;
            ALUOP_FUNCT:  alu_operation_o = funct_op;
            ALUOP_OPCODE: alu_operation_o = opcode_op;
            default:      alu_operation_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences instruction phases and drives every
// datapath enable, mux select and the ALU operation code.
//
// state       | meaning
// S_FETCH     | read instruction, load IR, PC <= PC+4
// S_DECODE    | branch target into ALUOut, dispatch on opcode
// S_MEM_ADDR  | effective address A + sign-ext imm
// S_MEM_READ  | data memory read (lw)
// S_MEM_WB    | memory data into rt (lw)
// S_MEM_WRITE | data memory write (sw)
// S_R_EXEC    | R-type ALU operation by funct
// S_R_WB      | ALU result into rd
// S_I_EXEC    | immediate ALU operation
// S_I_WB      | ALU result into rt
// S_BRANCH    | compare A-B, conditional PC <= ALUOut
// S_JUMP      | PC <= jump target
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [3:0] ALUOperation,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ImmZeroExt,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       Illegal
);

    state_t     state_q, state_d;
    aluop_t     alu_class;
    logic       alu_en;
    logic [3:0] dec_operation;
    logic       funct_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // ALU class depends on state only, keeping the decoder free of loops.
    always_comb begin
        alu_class = ALUOP_ADD;
        alu_en    = 1'b0;
        case (state_q)
            S_FETCH, S_DECODE, S_MEM_ADDR: alu_en = 1'b1;
            S_R_EXEC, S_R_WB: begin
                alu_en    = 1'b1;
                alu_class = ALUOP_FUNCT;
            end
            S_I_EXEC, S_I_WB: begin
                alu_en    = 1'b1;
                alu_class = ALUOP_OPCODE;
            end
            S_BRANCH: begin
                alu_en    = 1'b1;
                alu_class = ALUOP_SUB;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .opcode_i        (Opcode),
        .funct_i         (Funct),
        .alu_op_i        (alu_class),
        .alu_operation_o (dec_operation),
        .funct_valid_o   (funct_valid)
    );

    assign ALUOperation = (reset && alu_en) ? dec_operation : ALU_AND;

    always_comb begin
        state_d    = state_q;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ImmZeroExt = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 2'd0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        Illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'd1;
                PCWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'd3;
                case (Opcode)
                    OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
                    OP_RTYPE:                        state_d = S_R_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
                    OP_J:                            state_d = S_JUMP;
                    default: begin
                        Illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                state_d = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA = is_shift(Funct) ? 2'd2 : 2'd1;
                if (funct_valid) begin
                    state_d = S_R_WB;
                end else begin
                    Illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_I_EXEC, S_I_WB: begin
                ALUSrcA    = 2'd1;
                ALUSrcB    = 2'd2;
                ImmZeroExt = (Opcode == OP_ANDI) || (Opcode == OP_ORI) || (Opcode == OP_LUI);
                RegWrite   = (state_q == S_I_WB);
                state_d    = (state_q == S_I_EXEC) ? S_I_WB : S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'd1;
                PCSrc   = 2'd1;
                PCWrite = (Opcode == OP_BNE) ? ~Zero : Zero;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'd2;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Outputs are forced low for as long as reset is held.
        if (!reset) begin
            ALUSrcA    = 2'd0;
            ALUSrcB    = 2'd0;
            ImmZeroExt = 1'b0;
            PCWrite    = 1'b0;
            PCSrc      = 2'd0;
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            Illegal    = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control unit: a Moore FSM that sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives every datapath enable and mux select. It is the producing end of the ALU interface. It generates the 4-bit ALUOperation code consumed by the ALU and samples the ALU's Zero flag to resolve branches. It sits between the instruction register (opcode/funct) and the shared single-ALU datapath.

## Interface
- No parameters; all encodings are fixed constants in the shared package.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; state forced to FETCH, all outputs 0 while low
- Opcode  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, sampled in BRANCH only
- ALUOperation  out  4  AND=0, OR=1, NOR=2, ADD=3, SUB=4, LUI=5, SLL=6, SRL=7
- ALUSrcA  out  2  0=PC, 1=reg A (rs), 2=reg B (rt, shift source)
- ALUSrcB  out  2  0=reg B, 1=const 4, 2=extended imm, 3=sign-ext imm<<2
- ImmZeroExt  out  1  1=zero-extend imm (andi/ori/lui), 0=sign-extend
- PCWrite  out  1  load PC
- PCSrc  out  2  0=ALUResult, 1=ALUOut, 2=jump target {PC[31:28],IR[25:0],2'b0}
- IorD, MemRead, MemWrite, IRWrite  out  1 each  memory-side controls
- RegWrite, RegDst, MemtoReg  out  1 each  register-file controls (RegDst 1=rd)
- Illegal  out  1  one-cycle pulse on an unsupported opcode/funct

## Operation
- Supported:
  - R-type (opcode 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, sll 0x00, srl 0x02.
  - I-type: addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - Jump: j 0x02.
- Per-state outputs (any output not listed is 0):
  - FETCH: MemRead, IRWrite, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD, PCWrite, PCSrc=0. Next state DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=3, ADD (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEM_ADDR
    - R-type → R_EXEC
    - addi/andi/ori/lui → I_EXEC
    - beq/bne → BRANCH
    - j → JUMP
    - anything else → FETCH with Illegal=1
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD. Next state MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ: MemRead, IorD=1. Next state MEM_WB.
  - MEM_WB: RegWrite, RegDst=0, MemtoReg=1. Next state FETCH.
  - MEM_WRITE: MemWrite, IorD=1. Next state FETCH.
  - R_EXEC: ALUSrcB=0; ALUSrcA=2 for sll/srl, else 1; ALUOperation from funct. Unknown funct → FETCH with Illegal=1 and no writes. Otherwise next state R_WB.
  - R_WB: RegWrite, RegDst=1, MemtoReg=0; hold the R_EXEC ALUOperation. Next state FETCH.
  - I_EXEC: ALUSrcA=1, ALUSrcB=2; ImmZeroExt=1 for andi/ori/lui; ALUOperation addi→ADD, andi→AND, ori→OR, lui→LUI. Next state I_WB.
  - I_WB: RegWrite, RegDst=0, MemtoReg=0; hold I_EXEC ALU controls. Next state FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCSrc=1. PCWrite=Zero (beq) or !Zero (bne); this is the only Mealy output. Next state FETCH.
  - JUMP: PCWrite, PCSrc=2. Next state FETCH.
- All other outputs decode combinationally from the state register and the latched opcode/funct. Opcode and Funct are stable from DECODE onward because IR changes only in FETCH.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, I-type 4, beq/bne 3, j 3, illegal 2 (or 3 for an illegal funct).
- Reset assert at any cycle aborts immediately, with no partial writes afterwards. Release at edge N means FETCH outputs are visible from N and the first IR load occurs at edge N+1.
- Zero is sampled combinationally in BRANCH, so the ALU result must settle within the same cycle.
- An Illegal pulse never coincides with RegWrite, MemWrite or PCWrite.

## Structure
- Shared package mips_pkg holds the ALU operation localparams (same 4-bit codes as the ALU), opcode/funct constants and the state encoding (4-bit).
- Sub-module alu_decoder is combinational: inputs Opcode, Funct and a 2-bit ALUOp class (ADD / SUB / by-funct / by-opcode); outputs ALUOperation and a funct-valid flag.
- Top level holds the state register, next-state logic and output decode.

## Test plan
- Reset low mid-MEM_WRITE → MemWrite drops to 0 asynchronously. After release, the first cycle shows MemRead=1, IRWrite=1, PCWrite=1.
- add (Opcode 0x00, Funct 0x20) → 4 cycles. R_EXEC shows ALUOperation=3, ALUSrcA=1; R_WB shows RegWrite=1, RegDst=1.
- sll (Funct 0x00) → ALUSrcA=2 and ALUOperation=6 in R_EXEC. srl (Funct 0x02) → ALUOperation=7.
- lw 0x23 → exactly 5 cycles with MEM_READ IorD=1 and MEM_WB MemtoReg=1. sw 0x2B → 4 cycles and MemWrite for exactly one cycle.
- beq with Zero=1 → PCWrite=1, PCSrc=1 in BRANCH. beq with Zero=0 → PCWrite=0. bne gives the inverted results.
- lui 0x0F → ImmZeroExt=1 and ALUOperation=5. Opcode 0x3F → Illegal pulses in DECODE, returns to FETCH, and no write strobes are asserted.
